// File: rtl/fib_pkg.sv
// Shared constants and FSM state encoding for the Fibonacci writer/reader pair.
package fib_pkg;

    localparam int FIB_DATA_W = 32;
    localparam int FIB_ADDR_W = 5;
    localparam int FIB_DEPTH  = 2 ** FIB_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        FIN
    } fib_state_t;

    function automatic int fib_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/fib_out_reg.sv
// Output holding register: loads a captured word and keeps it valid until the sink takes it.
module fib_out_reg
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/fib_result_reader.sv
// Walks storage addresses 0..len-1 and streams each returned word out over valid/ready.
//   state   | meaning
//   IDLE    | waiting for start
//   ISSUE   | read strobe for entry idx
//   WAIT    | counting down storage read latency
//   PRESENT | word held on out_data until the sink accepts it
//   FIN     | one-cycle done pulse
module fib_result_reader
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W,
    parameter int ADDR_W = FIB_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int              DEPTH    = fib_depth(ADDR_W);
    localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      LAT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    if (RD_LAT < 0 || RD_LAT > 2) begin : g_bad_rd_lat
        $error("fib_result_reader: RD_LAT must be 0, 1 or 2");
    end

    fib_state_t        r_state;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   r_len_q;
    logic [1:0]        r_lat_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_last;
    logic              w_hs;
    logic              w_load;
    logic              w_valid;
    logic [ADDR_W:0]   w_idx_nxt;

    assign w_last    = (r_idx == r_len_q - 1'b1);
    assign w_hs      = (r_state == PRESENT) && w_valid && out_ready;
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_load    = ((r_state == ISSUE) && (RD_LAT == 0)) ||
                       ((r_state == WAIT) && (r_lat_cnt == 2'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_len_q   <= '0;
            r_lat_cnt <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // a start coinciding with the zero-length done pulse is dropped
                    if (start && !r_done) begin
                        if (len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_len_q   <= (len > LEN_MAX) ? LEN_MAX : len;
                            r_idx     <= '0;
                            r_rd_addr <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (RD_LAT == 0) begin
                        r_state <= PRESENT;
                    end else begin
                        r_lat_cnt <= LAT_INIT;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == 2'd0) begin
                        r_state <= PRESENT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                PRESENT: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_rd_addr <= w_idx_nxt[ADDR_W-1:0];
                            r_state   <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fib_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (rd_data),
        .i_ready(out_ready),
        .o_data (out_data),
        .o_valid(w_valid)
    );

    assign rd_en     = (r_state == ISSUE);
    assign rd_addr   = r_rd_addr;
    assign out_valid = w_valid;
    assign out_last  = (r_state == PRESENT) && w_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/fib_result_reader.md
Name: fib_result_reader

Overview:
Read-side counterpart to the Fibonacci sequence controller, which writes successive terms into the register file and RAM. On a start pulse, this block walks addresses 0..len-1 of that storage and issues one read per entry. It captures each returned word and streams it out over a valid/ready handshake to the display or serial sink. It replaces ad-hoc readout muxing and lets the sink apply backpressure.

Parameters:
DATA_W, 32, width of each stored word and of out_data
ADDR_W, 5, storage address width; DEPTH = 2**ADDR_W entries
RD_LAT, 1, storage read latency in cycles (0 = combinational register-file read, 1 or 2 = synchronous RAM read); other values are illegal and rejected by elaboration assertion

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begins a readout when idle
len  input  ADDR_W+1  number of entries to read, sampled on accepted start
rd_en  output  1  read strobe to storage, one cycle per entry
rd_addr  output  ADDR_W  read address to storage
rd_data  input  DATA_W  storage read data, valid RD_LAT cycles after rd_en
out_data  output  DATA_W  captured word
out_valid  output  1  out_data is valid
out_ready  input  1  sink accepts out_data when out_valid && out_ready
out_last  output  1  high with out_valid on the final entry
busy  output  1  readout in progress (state != IDLE)
done  output  1  one-cycle pulse after the final handshake, or on a zero-length start

Behaviour:
- Clock and reset: clk is the clock. Reset rst is asynchronous and active-high. It forces state=IDLE and clears every output to zero: rd_en, rd_addr, out_data, out_valid, out_last, busy, done. It also clears the internal index, length register and latency counter.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, FIN.
- IDLE:
  - On start with len==0: done=1 for the next cycle; stay IDLE.
  - On start with len!=0: latch len_q = min(len, DEPTH), set idx=0, go to ISSUE.
  - start is ignored in every other state.
- ISSUE: rd_en=1 and rd_addr=idx for exactly this cycle.
  - RD_LAT==0: capture rd_data into out_data this cycle and go to PRESENT.
  - Otherwise: load lat_cnt=RD_LAT-1 and go to WAIT.
- WAIT: rd_en=0; rd_addr holds.
  - When lat_cnt==0: capture rd_data into out_data and go to PRESENT.
  - Otherwise decrement lat_cnt.
- PRESENT: out_valid=1; out_data stays stable until the handshake completes; out_last = (idx == len_q-1).
  - Handshake with idx==len_q-1: go to FIN.
  - Handshake otherwise: idx++ and go to ISSUE.
  - Without a handshake: remain in PRESENT, with no limit on how long.
- FIN: done=1 for one cycle, out_valid=0, then go to IDLE.
- Latency:
  - Accepted start at cycle T gives rd_en at T+1 and first out_valid at T+2+RD_LAT.
  - Handshake at cycle k gives the next rd_en at k+1 and the next out_valid at k+2+RD_LAT.
  - Handshake on the last entry at cycle k gives done high during cycle k+1.
- Outputs are registered except rd_en and out_last, which are decoded from state.
- out_valid is low in every cycle where rd_en is high. A word is never presented before its read completes.
- Width and wrap rules:
  - idx is ADDR_W+1 bits, so len_q==DEPTH reads address DEPTH-1 last without wrapping.
  - rd_addr = idx[ADDR_W-1:0].
  - len > DEPTH clamps to DEPTH.
- Simultaneous events:
  - A start arriving in the same cycle as the done pulse is ignored.
  - A start one cycle later in IDLE is accepted.
- Reset mid-operation: the readout aborts immediately. No done pulse is produced and out_valid drops asynchronously.

Decomposition:
- Shared package fib_pkg: state enum (IDLE, ISSUE, WAIT, PRESENT, FIN), DATA_W/ADDR_W defaults, DEPTH derivation. The same constants are reused by the writer controller.
- One sub-module is natural: fib_out_reg, a DATA_W holding register with a load enable and valid/ready hold logic. The rest is a flat FSM.

Test Plan:
- Storage preloaded with 1,1,2,3,5,8,13,21; RD_LAT=1; len=8; out_ready=1 -> words 1,1,2,3,5,8,13,21 in order; out_last only on 21; done one cycle after the last handshake; first out_valid at T+3.
- Same contents; len=4; out_ready held low 5 cycles on word 2 -> out_data remains 2 with out_valid high throughout; no extra rd_en; remaining order 3, then done.
- len=0 start -> done pulse at T+1; rd_en and out_valid never assert; busy stays 0.
- len=40, DEPTH=32 -> exactly 32 reads at addresses 0..31; out_last on the address-31 word; no address wrap.
- RD_LAT=0 and RD_LAT=2 builds with len=3 -> first out_valid at T+2 and T+4 respectively; data correct.
- rst asserted while in PRESENT on entry 2 -> all outputs 0 immediately; no done pulse; a new start with len=2 yields 1,1.
